// File: rtl/processor_pkg.sv
// Shared definitions for the 8-bit accumulator teaching CPU: widths, opcodes, default ROM image.
package processor_pkg;

    localparam int INSTR_W = 8;
    localparam int DATA_W  = 8;
    localparam int NREGS   = 8;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LDI   = 4'h1,
        OP_MOVRA = 4'h2,
        OP_MOVAR = 4'h3,
        OP_ADD   = 4'h4,
        OP_ADDC  = 4'h5,
        OP_SUB   = 4'h6,
        OP_AND   = 4'h7,
        OP_OR    = 4'h8,
        OP_XOR   = 4'h9,
        OP_CLRC  = 4'hA,
        OP_SETC  = 4'hB,
        OP_JMP   = 4'hC,
        OP_JZ    = 4'hD,
        OP_JC    = 4'hE,
        OP_HALT  = 4'hF
    } opcode_e;

    // Word i lives at bits [i*8 +: 8]; listed here from address 15 down to 0.
    localparam logic [16*INSTR_W-1:0] DEFAULT_ROM = {
        8'h00, 8'h00, 8'h00, 8'hF0,
        8'h40, 8'h20, 8'h40, 8'h20,
        8'h40, 8'h20, 8'h40, 8'h20,
        8'h40, 8'h20, 8'h43, 8'h15
    };

endpackage

// File: rtl/processor_alu.sv
// Accumulator ALU: 9-bit add/add-with-carry/subtract, bitwise logic, carry set/clear, zero detect.
module processor_alu
    import processor_pkg::*;
(
    input  opcode_e           op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cy_i,
    output logic [DATA_W-1:0] res_o,
    output logic              cy_o,
    output logic              zero_o
);

    logic [DATA_W:0] wide;

    // The ninth bit of the subtraction is the borrow (a < b unsigned).
    always_comb begin
        wide  = '0;
        res_o = a_i;
        cy_o  = cy_i;
        case (op_i)
            OP_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                res_o = wide[DATA_W-1:0];
                cy_o  = wide[DATA_W];
            end
            OP_ADDC: begin
                wide  = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cy_i};
                res_o = wide[DATA_W-1:0];
                cy_o  = wide[DATA_W];
            end
            OP_SUB: begin
                wide  = {1'b0, a_i} - {1'b0, b_i};
                res_o = wide[DATA_W-1:0];
                cy_o  = wide[DATA_W];
            end
            OP_AND:  res_o = a_i & b_i;
            OP_OR:   res_o = a_i | b_i;
            OP_XOR:  res_o = a_i ^ b_i;
            OP_CLRC: cy_o  = 1'b0;
            OP_SETC: cy_o  = 1'b1;
            default: ;
        endcase
    end

    assign zero_o = (a_i == '0);

endmodule

// File: rtl/processor.sv
// Single-cycle accumulator CPU: combinational fetch/decode from PC, register file with live R3 input,
// accumulator and carry registers; HALT holds PC so the machine freezes until reset.
module processor
    import processor_pkg::*;
#(
    parameter int                              PC_W      = 4,
    parameter logic [INSTR_W*(2**PC_W)-1:0]    ROM_IMAGE = DEFAULT_ROM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] acc,
    output logic              cy
);

    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               cy_q, cy_d;
    logic [DATA_W-1:0]  regs_q [NREGS];

    logic [INSTR_W-1:0] instr;
    opcode_e            op;
    logic [2:0]         n;
    logic [3:0]         imm;
    logic [DATA_W-1:0]  rd;
    logic [DATA_W-1:0]  alu_res;
    logic               alu_cy;
    logic               acc_zero;

    assign instr = ROM_IMAGE[INSTR_W*int'(pc_q) +: INSTR_W];
    assign op    = opcode_e'(instr[7:4]);
    assign n     = instr[2:0];
    assign imm   = instr[3:0];

    // R3 has no storage of its own as far as software can tell: reads see the pin.
    assign rd = (n == 3'd3) ? r3 : regs_q[n];

    processor_alu u_alu (
        .op_i   (op),
        .a_i    (acc_q),
        .b_i    (rd),
        .cy_i   (cy_q),
        .res_o  (alu_res),
        .cy_o   (alu_cy),
        .zero_o (acc_zero)
    );

    always_comb begin
        acc_d = acc_q;
        cy_d  = cy_q;
        pc_d  = pc_q + 1'b1;
        case (op)
            OP_LDI:   acc_d = {4'b0, imm};
            OP_MOVAR: acc_d = rd;
            OP_ADD, OP_ADDC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CLRC, OP_SETC: begin
                acc_d = alu_res;
                cy_d  = alu_cy;
            end
            OP_JMP:   pc_d = PC_W'(imm);
            OP_JZ:    if (acc_zero) pc_d = PC_W'(imm);
            OP_JC:    if (cy_q)     pc_d = PC_W'(imm);
            OP_HALT:  pc_d = pc_q;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= '0;
            acc_q <= '0;
            cy_q  <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            acc_q <= acc_d;
            cy_q  <= cy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else if (op == OP_MOVRA && n != 3'd3) begin
            regs_q[n] <= acc_q;
        end
    end

    assign acc = acc_q;
    assign cy  = cy_q;

endmodule

// File: tb/tb_processor.sv
// Bench for processor: four instances (default ROM and three custom images) checked against queued expectations.
module tb_processor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] r3_dflt = 8'd6;
    logic [7:0] r3_ops  = 8'h5C;
    logic [7:0] r3_zero = 8'h00;

    logic [7:0] acc_dflt, acc_sub, acc_ops, acc_wrap;
    logic       cy_dflt, cy_sub, cy_ops, cy_wrap;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [127:0] ROM_SUB = {
        8'h00, 8'hF0, 8'hD0, 8'h11, 8'h1F, 8'hDC, 8'hE6, 8'h61,
        8'h15, 8'hF0, 8'h1F, 8'hE7, 8'h61, 8'h13, 8'h21, 8'h15
    };
    localparam logic [127:0] ROM_OPS = {
        8'hC0, 8'h00, 8'h30, 8'hA0, 8'h91, 8'h83, 8'hB0, 8'h71,
        8'h51, 8'hB0, 8'h1F, 8'h21, 8'h33, 8'h10, 8'h23, 8'h1A
    };
    localparam logic [127:0] ROM_WRAP = {
        8'h00, 8'h1F, 8'h00, 8'h1D, 8'h00, 8'h1B, 8'h00, 8'h19,
        8'h00, 8'h17, 8'h00, 8'h15, 8'h00, 8'h13, 8'h00, 8'h11
    };

    processor u_dflt (.clk(clk), .rst(rst), .r3(r3_dflt), .acc(acc_dflt), .cy(cy_dflt));
    processor #(.PC_W(4), .ROM_IMAGE(ROM_SUB))  u_sub  (.clk(clk), .rst(rst), .r3(r3_zero), .acc(acc_sub),  .cy(cy_sub));
    processor #(.PC_W(4), .ROM_IMAGE(ROM_OPS))  u_ops  (.clk(clk), .rst(rst), .r3(r3_ops),  .acc(acc_ops),  .cy(cy_ops));
    processor #(.PC_W(4), .ROM_IMAGE(ROM_WRAP)) u_wrap (.clk(clk), .rst(rst), .r3(r3_zero), .acc(acc_wrap), .cy(cy_wrap));

    always #5 clk = ~clk;

    // {cy, acc} expected after each edge, edge 1 first
    logic [8:0] seq_r3_6 [20] = '{9'h005, 9'h00B, 9'h00B, 9'h016, 9'h016, 9'h02C, 9'h02C, 9'h058, 9'h058, 9'h0B0,
                                  9'h0B0, 9'h160, 9'h160, 9'h160, 9'h160, 9'h160, 9'h160, 9'h160, 9'h160, 9'h160};
    logic [8:0] seq_r3_ff [14] = '{9'h005, 9'h104, 9'h104, 9'h008, 9'h008, 9'h010, 9'h010, 9'h020, 9'h020, 9'h040,
                                   9'h040, 9'h080, 9'h080, 9'h080};
    logic [8:0] seq_sub [20] = '{9'h005, 9'h005, 9'h003, 9'h1FE, 9'h1FE, 9'h105, 9'h000, 9'h000, 9'h000, 9'h001,
                                 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001, 9'h001};
    logic [8:0] seq_ops [20] = '{9'h00A, 9'h00A, 9'h000, 9'h05C, 9'h05C, 9'h00F, 9'h10F, 9'h06C, 9'h04C, 9'h14C,
                                 9'h15C, 9'h100, 9'h000, 9'h000, 9'h000, 9'h000, 9'h00A, 9'h00A, 9'h000, 9'h05C};

    logic [8:0] q_dflt [$];
    logic [8:0] q_sub  [$];
    logic [8:0] q_ops  [$];
    logic [8:0] q_wrap [$];

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got cy=%0b acc=0x%02h, expected cy=%0b acc=0x%02h",
                     tag, got[8], got[7:0], exp[8], exp[7:0]);
        end
    endtask

    task automatic apply_reset(input logic [7:0] r3v);
        rst     = 1'b1;
        r3_dflt = r3v;
        @(negedge clk);
        chk("reset_dflt", {cy_dflt, acc_dflt}, 9'h000);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Pops one expectation per queue per edge; empty queues are not checked.
    task automatic run_edges(input int n, input string phase);
        logic [8:0] e;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (q_dflt.size() > 0) begin e = q_dflt.pop_front(); chk($sformatf("%s_dflt_e%0d", phase, k), {cy_dflt, acc_dflt}, e); end
            if (q_sub.size()  > 0) begin e = q_sub.pop_front();  chk($sformatf("%s_sub_e%0d",  phase, k), {cy_sub,  acc_sub},  e); end
            if (q_ops.size()  > 0) begin e = q_ops.pop_front();  chk($sformatf("%s_ops_e%0d",  phase, k), {cy_ops,  acc_ops},  e); end
            if (q_wrap.size() > 0) begin e = q_wrap.pop_front(); chk($sformatf("%s_wrap_e%0d", phase, k), {cy_wrap, acc_wrap}, e); end
        end
    endtask

    initial begin
        int pc;

        // Scenario 1: r3=6 on default ROM, plus the three custom images
        apply_reset(8'd6);
        for (int k = 1; k <= 20; k++) begin
            q_dflt.push_back(seq_r3_6[k-1]);
            q_sub.push_back(seq_sub[k-1]);
            q_ops.push_back(seq_ops[k-1]);
            pc = (k - 1) % 16;
            q_wrap.push_back((pc % 2 == 0) ? 9'(pc + 1) : 9'(pc));
        end
        run_edges(20, "r3_6");

        // Scenario 2: r3=0xFF exercises carry-out
        apply_reset(8'hFF);
        foreach (seq_r3_ff[i]) q_dflt.push_back(seq_r3_ff[i]);
        run_edges(14, "r3_ff");

        // Scenario 3: asynchronous reset between edges after edge 7, then full rerun
        apply_reset(8'd6);
        for (int k = 0; k < 7; k++) q_dflt.push_back(seq_r3_6[k]);
        run_edges(7, "pre_rst");
        #2 rst = 1'b1;
        #1 chk("async_rst", {cy_dflt, acc_dflt}, 9'h000);
        @(negedge clk);
        chk("rst_held", {cy_dflt, acc_dflt}, 9'h000);
        rst = 1'b0;
        for (int k = 0; k < 14; k++) q_dflt.push_back(seq_r3_6[k]);
        run_edges(14, "rerun");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
